// File: rtl/ori_fifo_rd_pkg.sv
// Shared types and constants for the ori_fifo read-side stream adapter.
package ori_fifo_rd_pkg;

    localparam int BEAT_CNT_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/ori_fifo_rd_stream_if.sv
// FIFO read port plus output valid/ready stream of the ori_fifo read adapter.
// master = adapter side, slave = FIFO/consumer side.
interface ori_fifo_rd_stream_if
    import ori_fifo_rd_pkg::*;
#(
    parameter int WIDTH = 512
);
    localparam int W = (WIDTH < 1) ? 1 : WIDTH;

    logic                  fifo_empty_i;
    logic                  fifo_rd_en_o;
    logic [W-1:0]          fifo_rd_data_i;
    logic                  m_valid_o;
    logic [W-1:0]          m_data_o;
    logic                  m_ready_i;
    logic [BEAT_CNT_W-1:0] beat_cnt_o;

    modport master (
        input  fifo_empty_i,
        output fifo_rd_en_o,
        input  fifo_rd_data_i,
        output m_valid_o,
        output m_data_o,
        input  m_ready_i,
        output beat_cnt_o
    );

    modport slave (
        output fifo_empty_i,
        input  fifo_rd_en_o,
        output fifo_rd_data_i,
        input  m_valid_o,
        input  m_data_o,
        output m_ready_i,
        input  beat_cnt_o
    );

endinterface

// File: rtl/ori_skid2.sv
// Generic 2-entry registered buffer (head/tail) with push, pop and occupancy.
//   state | meaning
//   EMPTY | no entries, head/tail undefined
//   ONE   | head valid
//   TWO   | head and tail valid, tail is the younger entry
module ori_skid2
    import ori_fifo_rd_pkg::*;
#(
    parameter int WIDTH = 512
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push_i,
    input  logic [((WIDTH < 1) ? 1 : WIDTH)-1:0] push_data_i,
    input  logic                                 pop_i,
    output occ_e                                 occ_o,
    output logic [((WIDTH < 1) ? 1 : WIDTH)-1:0] head_o
);
    localparam int W = (WIDTH < 1) ? 1 : WIDTH;

    occ_e         occ_q, occ_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         pop;

    assign pop = pop_i && (occ_q != EMPTY);

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            EMPTY: begin
                if (push_i) begin
                    occ_d  = ONE;
                    head_d = push_data_i;
                end
            end
            ONE: begin
                if (push_i && pop) begin
                    head_d = push_data_i;
                end else if (push_i) begin
                    occ_d  = TWO;
                    tail_d = push_data_i;
                end else if (pop) begin
                    occ_d = EMPTY;
                end
            end
            TWO: begin
                // A push here only ever accompanies a pop; keep it ordered anyway.
                if (pop) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = push_data_i;
                    end else begin
                        occ_d = ONE;
                    end
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

endmodule

// File: rtl/ori_fifo_rd_stream.sv
// Read-side adapter: issues rd_en into a 1-cycle-latency FIFO and presents a registered valid/ready stream.
// Optional accepted-beat counter enabled by defining ORI_FIFO_RD_BEAT_CNT_EN.
module ori_fifo_rd_stream
    import ori_fifo_rd_pkg::*;
#(
    parameter int WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    ori_fifo_rd_stream_if.master bus
);
    localparam int W = (WIDTH < 1) ? 1 : WIDTH;

    occ_e         occ;
    logic [1:0]   occ_n;
    logic [W-1:0] head;
    logic         m_valid;
    logic         pop;
    logic         rd_en;
    logic [2:0]   demand;
    logic         inflight_q, inflight_d;

    assign occ_n   = occ;
    assign m_valid = (occ != EMPTY);
    assign pop     = m_valid && bus.m_ready_i;

    // Slots already owed (buffered + in flight) after this cycle's pop must leave room.
    always_comb begin
        demand     = 3'(occ_n) + 3'(inflight_q) - 3'(pop);
        rd_en      = !rst && !bus.fifo_empty_i && (demand < 3'd2);
        inflight_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    ori_skid2 #(
        .WIDTH (W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (bus.fifo_rd_data_i),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (head)
    );

    assign bus.fifo_rd_en_o = rd_en;
    assign bus.m_valid_o    = m_valid;
    assign bus.m_data_o     = head;

`ifdef ORI_FIFO_RD_BEAT_CNT_EN
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.beat_cnt_o = beat_cnt_q;
`else
    assign bus.beat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ori_fifo_rd_stream.sv
// Directed bench for ori_fifo_rd_stream with a behavioural 1-cycle-latency FIFO in front of it.
module tb_ori_fifo_rd_stream;
    import ori_fifo_rd_pkg::*;

    localparam int W = 32;

`ifdef ORI_FIFO_RD_BEAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ori_fifo_rd_stream_if #(.WIDTH(W)) bus ();

    ori_fifo_rd_stream #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // FIFO model: read data appears the cycle after rd_en.
    logic [31:0] fifo_mem [256];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    int unsigned viol   = 0;
    logic        fifo_flush;

    assign bus.fifo_empty_i = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en_o && bus.fifo_empty_i) viol <= viol + 1;
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en_o) begin
            bus.fifo_rd_data_i <= fifo_mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] v);
        fifo_mem[wr_ptr[7:0]] = v;
        wr_ptr++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fifo_flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fifo_flush = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!bus.m_valid_o && n < budget) begin
            tick();
            n++;
        end
        check(tag, bus.m_valid_o, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int got;
        int pushed;
        int cyc;
        int nb;

        rst = 1'b1;
        fifo_flush = 1'b1;
        bus.m_ready_i = 1'b0;

        // Reset with three words waiting, then release.
        @(negedge clk);
        @(negedge clk);
        fifo_flush = 1'b0;
        push_word(32'hA);
        push_word(32'hB);
        push_word(32'hC);
        bus.m_ready_i = 1'b1;
        #1;
        check("rst_rd_en", bus.fifo_rd_en_o, 1'b0);
        check("rst_valid", bus.m_valid_o, 1'b0);
        check("rst_cnt", bus.beat_cnt_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("c0_rd_valid", {bus.fifo_rd_en_o, bus.m_valid_o}, 2'b10);
        tick();
        check("c1_valid_rd", {bus.m_valid_o, bus.fifo_rd_en_o}, 2'b01);
        tick();
        check("c2_beat_a", {bus.m_valid_o, bus.m_data_o}, {1'b1, 32'hA});
        tick();
        check("c3_beat_b", {bus.m_valid_o, bus.m_data_o}, {1'b1, 32'hB});
        tick();
        check("c4_beat_c", {bus.m_valid_o, bus.m_data_o}, {1'b1, 32'hC});
        tick();
        check("c5_drained", {bus.m_valid_o, bus.fifo_rd_en_o}, 2'b00);
        check("cnt_abc", bus.beat_cnt_o, CNT_EN ? 3 : 0);

        // Empty FIFO, consumer ready: nothing moves.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle", {bus.fifo_rd_en_o, bus.m_valid_o}, 2'b00);
        end

        // 100-word full-throughput stream.
        do_reset();
        for (int i = 0; i < 100; i++) push_word(32'h1000 + i);
        #1;
        lat = 0;
        while (!bus.m_valid_o && lat < 10) begin
            tick();
            lat++;
        end
        check("stream_latency", lat, 2);
        for (int i = 0; i < 100; i++) begin
            check("stream_beat", {bus.m_valid_o, bus.m_data_o}, {1'b1, 32'h1000 + i});
            tick();
        end
        check("stream_end", bus.m_valid_o, 1'b0);
        check("cnt_100", bus.beat_cnt_o, CNT_EN ? 100 : 0);

        // Backpressure for 10 cycles mid-stream.
        do_reset();
        for (int i = 0; i < 20; i++) push_word(32'h2000 + i);
        #1;
        wait_valid("bp_start", 10);
        for (int i = 0; i < 5; i++) begin
            check("bp_pre", {bus.m_valid_o, bus.m_data_o}, {1'b1, 32'h2000 + i});
            tick();
        end
        bus.m_ready_i = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("bp_hold", {bus.m_valid_o, bus.m_data_o}, {1'b1, 32'h2005});
            tick();
        end
        check("bp_occ", dut.u_skid.occ_q, TWO);
        check("bp_no_rd", bus.fifo_rd_en_o, 1'b0);
        check("bp_fifo_left", wr_ptr - rd_ptr, 13);
        bus.m_ready_i = 1'b1;
        #1;
        for (int i = 5; i < 20; i++) begin
            wait_valid("bp_resume_wait", 5);
            check("bp_post", bus.m_data_o, 32'h2000 + i);
            tick();
        end
        check("bp_end", bus.m_valid_o, 1'b0);

        // Random ready and random FIFO fill, in-order scoreboard.
        do_reset();
        got = 0;
        pushed = 0;
        cyc = 0;
        while (got < 10000 && cyc < 40000) begin
            @(negedge clk);
            bus.m_ready_i = 1'($urandom_range(0, 1));
            if (pushed < 10000 && (wr_ptr - rd_ptr) < 200 && $urandom_range(0, 2) == 0) begin
                nb = $urandom_range(1, 4);
                for (int j = 0; j < nb && pushed < 10000; j++) begin
                    push_word(32'h5000_0000 + pushed);
                    pushed++;
                end
            end
            #1;
            if (bus.m_valid_o && bus.m_ready_i) begin
                check("rand_beat", bus.m_data_o, 32'h5000_0000 + got);
                got++;
            end
            cyc++;
        end
        check("rand_count", got, 10000);
        check("rd_while_empty", viol, 0);

        // Reset while the buffer is full.
        do_reset();
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) push_word(32'h6000 + i);
        #1;
        wait_valid("rf_start", 10);
        for (int i = 0; i < 2; i++) begin
            check("rf_pre", bus.m_data_o, 32'h6000 + i);
            tick();
        end
        bus.m_ready_i = 1'b0;
        tick();
        tick();
        tick();
        check("rf_occ", dut.u_skid.occ_q, TWO);
        rst = 1'b1;
        fifo_flush = 1'b1;
        tick();
        check("rf_valid", {bus.m_valid_o, bus.fifo_rd_en_o}, 2'b00);
        check("rf_cnt", bus.beat_cnt_o, 0);
        rst = 1'b0;
        fifo_flush = 1'b0;
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) push_word(32'h7000 + i);
        #1;
        for (int i = 0; i < 3; i++) begin
            wait_valid("rf_post_wait", 5);
            check("rf_post", bus.m_data_o, 32'h7000 + i);
            tick();
        end
        check("rf_end", bus.m_valid_o, 1'b0);

        // Reset while streaming with a read in flight.
        for (int i = 0; i < 10; i++) push_word(32'h8000 + i);
        #1;
        wait_valid("rs_start", 10);
        check("rs_pre", bus.m_data_o, 32'h8000);
        rst = 1'b1;
        fifo_flush = 1'b1;
        tick();
        check("rs_valid", bus.m_valid_o, 1'b0);
        rst = 1'b0;
        fifo_flush = 1'b0;
        push_word(32'h9000);
        push_word(32'h9001);
        #1;
        for (int i = 0; i < 2; i++) begin
            wait_valid("rs_post_wait", 5);
            check("rs_post", bus.m_data_o, 32'h9000 + i);
            tick();
        end
        check("rs_end", bus.m_valid_o, 1'b0);
        check("rs_cnt", bus.beat_cnt_o, CNT_EN ? 2 : 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
